// File: rtl/duck_pkg.sv
// Shared types and screen constants for the duck spawn path.
package duck_pkg;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      DELAY   = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } spawner_state_t;

   typedef struct packed {
      logic [10:0] x;
      logic        dir;
      logic [1:0]  speed;
   } spawn_req_t;

endpackage

// File: rtl/spawn_delay_timer.sv
// Down-counter for the inter-spawn delay; expired is high while the count is zero.
module spawn_delay_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] count,
   output logic        expired
);

   logic [31:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= count;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 32'd1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/duck_spawner.sv
// Turns one LFSR word per duck into a delayed, handshaked spawn request
// for a round of MAX_DUCKS ducks.
module duck_spawner
   import duck_pkg::*;
#(
   parameter int RAND_W     = 16,
   parameter int X_MIN      = 32,
   parameter int X_SPAN     = 960,
   parameter int DELAY_BASE = 1_000_000,
   parameter int DELAY_STEP = 4_000_000,
   parameter int MAX_DUCKS  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [RAND_W-1:0] random,
   output logic              rand_en,
   output logic              spawn_valid,
   input  logic              spawn_ready,
   output logic [10:0]       spawn_x,
   output logic              spawn_dir,
   output logic [1:0]        spawn_speed,
   output logic [3:0]        ducks_left,
   output logic              round_done
);

   spawner_state_t state_reg, state_next;
   spawn_req_t     req_reg;
   logic [RAND_W-1:0] rnd_q;
   logic [31:0]    x_prod;
   logic [31:0]    delay_count;
   logic           abort;
   logic           accept;
   logic           expired;

   // rnd_q is the word seen during CAPTURE; the LFSR steps on the same edge.
   assign rnd_q       = random;
   assign x_prod      = 32'(rnd_q[9:0]) * 32'(X_SPAN);
   assign delay_count = 32'(DELAY_BASE) + 32'(rnd_q[15:13]) * 32'(DELAY_STEP);

   assign abort  = !start && (state_reg == CAPTURE || state_reg == DELAY || state_reg == PRESENT);
   assign accept = start && (state_reg == PRESENT) && spawn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = CAPTURE;
         CAPTURE: state_next = start ? DELAY : IDLE;
         DELAY: begin
            if (!start)       state_next = IDLE;
            else if (expired) state_next = PRESENT;
         end
         PRESENT: begin
            if (!start)      state_next = IDLE;
            else if (accept) state_next = (ducks_left == 4'd1) ? DONE : CAPTURE;
         end
         DONE:    if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_reg    <= '0;
         ducks_left <= '0;
         round_done <= 1'b0;
      end else begin
         round_done <= accept && (ducks_left == 4'd1);
         if (state_reg == IDLE && start) begin
            ducks_left <= 4'(MAX_DUCKS);
         end else if (abort) begin
            ducks_left <= '0;
         end else if (accept) begin
            ducks_left <= ducks_left - 4'd1;
         end
         if (state_reg == CAPTURE && start) begin
            req_reg.x     <= 11'(32'(X_MIN) + (x_prod >> 10));
            req_reg.dir   <= rnd_q[10];
            req_reg.speed <= rnd_q[12:11];
         end
      end
   end

   spawn_delay_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state_reg == CAPTURE),
      .clear   (abort),
      .count   (delay_count),
      .expired (expired)
   );

   assign rand_en     = (state_reg == CAPTURE);
   assign spawn_valid = (state_reg == PRESENT);
   assign spawn_x     = req_reg.x;
   assign spawn_dir   = req_reg.dir;
   assign spawn_speed = req_reg.speed;

endmodule

// File: tb/tb_duck_spawner.sv
// Randomised bench for duck_spawner with a small arithmetic reference model.
module tb_duck_spawner;

   localparam int X_MIN = 32, X_SPAN = 960;
   localparam int DBASE = 4, DSTEP = 2, NDUCKS = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] random;
   logic        rand_en, spawn_valid, spawn_ready, spawn_dir, round_done;
   logic [10:0] spawn_x;
   logic [1:0]  spawn_speed;
   logic [3:0]  ducks_left;

   int errors = 0;
   int checks = 0;
   int model_left;

   duck_spawner #(
      .RAND_W(16), .X_MIN(X_MIN), .X_SPAN(X_SPAN),
      .DELAY_BASE(DBASE), .DELAY_STEP(DSTEP), .MAX_DUCKS(NDUCKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .random(random),
      .rand_en(rand_en), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_dir(spawn_dir), .spawn_speed(spawn_speed),
      .ducks_left(ducks_left), .round_done(round_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: x is the 10-bit fraction scaled onto the spawn span.
   function automatic int model_x(input logic [15:0] r);
      return X_MIN + (int'(r[9:0]) * X_SPAN) / 1024;
   endfunction

   function automatic int model_delay(input logic [15:0] r);
      return DBASE + int'(r[15:13]) * DSTEP;
   endfunction

   // Called just after the edge that sampled start (or accepted the previous duck).
   task automatic run_duck(input logic [15:0] r, input int bp);
      int n, en_cnt;
      random      = r;
      spawn_ready = (bp == 0);
      n           = 0;
      en_cnt      = int'(rand_en);
      while (!spawn_valid && n < 200) begin
         tick();
         n++;
         en_cnt += int'(rand_en);
      end
      $display("duck r=%h x=%0d dir=%0d speed=%0d latency=%0d left=%0d",
               r, spawn_x, spawn_dir, spawn_speed, n, ducks_left);
      check_eq("valid_latency", n, model_delay(r) + 2);
      check_eq("rand_en_pulses", en_cnt, 1);
      check_eq("spawn_x", spawn_x, model_x(r));
      check_eq("spawn_dir", spawn_dir, r[10]);
      check_eq("spawn_speed", spawn_speed, r[12:11]);
      for (int i = 0; i < bp; i++) begin
         tick();
         check_eq("bp_valid", spawn_valid, 1);
         check_eq("bp_x", spawn_x, model_x(r));
         check_eq("bp_dir_speed", {spawn_dir, spawn_speed}, {r[10], r[12:11]});
         check_eq("bp_left", ducks_left, model_left);
      end
      spawn_ready = 1'b1;
      tick();
      model_left--;
      check_eq("left_after_accept", ducks_left, model_left);
      check_eq("valid_drop", spawn_valid, 0);
      check_eq("round_done", round_done, model_left == 0);
   endtask

   task automatic begin_round();
      start = 1'b1;
      tick();
      model_left = NDUCKS;
      check_eq("left_loaded", ducks_left, NDUCKS);
   endtask

   task automatic finish_round();
      int done_seen, act;
      done_seen = 0;
      act = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         done_seen += int'(round_done);
         act += int'(spawn_valid) + int'(rand_en);
      end
      check_eq("done_single_pulse", done_seen, 0);
      check_eq("done_hold_quiet", act, 0);
      check_eq("done_left_zero", ducks_left, 0);
      start = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet;
      logic [15:0] r;
      rst_n = 1'b0; start = 1'b0; spawn_ready = 1'b1; random = 16'h0;
      #22;
      check_eq("reset_outputs",
               {spawn_valid, rand_en, round_done, spawn_x, spawn_dir, spawn_speed, ducks_left}, 0);
      rst_n = 1'b1;
      tick(); tick();
      check_eq("idle_quiet", {spawn_valid, rand_en}, 0);

      // Directed round: the three reference words, first duck held off by backpressure.
      begin_round();
      run_duck(16'h3A55, 20);
      run_duck(16'h0000, 0);
      run_duck(16'h03FF, 0);
      finish_round();

      // Abort during the delay of duck 2.
      begin_round();
      run_duck(16'h3A55, 0);
      random = 16'hE000;
      tick(); tick();
      start = 1'b0;
      tick();
      check_eq("abort_left", ducks_left, 0);
      check_eq("abort_valid", spawn_valid, 0);
      quiet = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         quiet += int'(spawn_valid) + int'(round_done) + int'(rand_en);
      end
      check_eq("abort_quiet", quiet, 0);
      begin_round();
      for (int d = 0; d < NDUCKS; d++) run_duck(16'($urandom), 0);
      finish_round();

      // Random rounds with random backpressure.
      for (int k = 0; k < 3; k++) begin
         begin_round();
         for (int d = 0; d < NDUCKS; d++) begin
            r = 16'($urandom);
            run_duck(r, int'($urandom_range(0, 5)));
         end
         finish_round();
      end

      // Asynchronous reset while a request is presented.
      begin_round();
      random = 16'h1234;
      spawn_ready = 1'b0;
      quiet = 0;
      while (!spawn_valid && quiet < 200) begin
         tick();
         quiet++;
      end
      check_eq("pre_reset_valid", spawn_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_reset_outputs",
               {spawn_valid, rand_en, round_done, spawn_x, spawn_dir, spawn_speed, ducks_left}, 0);
      start = 1'b0;
      spawn_ready = 1'b1;
      #4 rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         quiet += int'(spawn_valid) + int'(rand_en) + int'(ducks_left != 0);
      end
      check_eq("post_reset_quiet", quiet, 0);
      begin_round();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
